// File: rtl/pipe_stage_buf.sv
// Pipeline stage register carrying a data and a control bundle under valid/ready.
// Supports synchronous flush and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W   = 165,
  parameter int unsigned       CTRL_W   = 6,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int unsigned       SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              accept, drain;

  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= CTRL_RST;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

    assign in_ready  = ~s_valid_q;
    assign occupancy = {s_valid_q, m_valid_q & ~s_valid_q};

    // The skid entry is only ever valid while main is valid; it refills main on drain.
    always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;
      if (flush) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = CTRL_RST;
        s_valid_d = 1'b0;
        s_ctrl_d  = CTRL_RST;
      end else if (s_valid_q) begin
        if (drain) begin
          m_data_d  = s_data_q;
          m_ctrl_d  = s_ctrl_q;
          s_valid_d = 1'b0;
          s_ctrl_d  = CTRL_RST;
        end
      end else if (m_valid_q) begin
        if (accept && drain) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (accept) begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
          s_ctrl_d  = in_ctrl;
        end else if (drain) begin
          m_valid_d = 1'b0;
          m_ctrl_d  = CTRL_RST;
        end
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_valid_q <= 1'b0;
        s_data_q  <= '0;
        s_ctrl_q  <= CTRL_RST;
      end else begin
        s_valid_q <= s_valid_d;
        s_data_q  <= s_data_d;
        s_ctrl_q  <= s_ctrl_d;
      end
    end
  end else begin : g_noskid
    assign in_ready  = ~m_valid_q | out_ready;
    assign occupancy = {1'b0, m_valid_q};

    always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      if (flush) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = CTRL_RST;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else if (drain) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = CTRL_RST;
      end
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register that replaces the fixed per-field stage registers between pipeline stages such as MEM and WB. It carries a generic data bundle and a control bundle under a valid/ready handshake. It adds synchronous flush (bubble insertion) and optional 2-entry skid buffering, so upstream `in_ready` is fully registered. One instance sits at each stage boundary.

## Interface
- `DATA_W`, default 165: width of the data bundle (ALU result, jump PC, load data, immediate, order PC, Rd).
- `CTRL_W`, default 6: width of the control bundle (jal, jalr, lui, U_type, MemtoReg, RegWrite).
- `CTRL_RST`, default 0: control value driven on reset, flush and bubble cycles.
- `SKID`, default 1:
  - 1: 2-entry skid buffer, registered `in_ready`.
  - 0: single register, combinational `in_ready`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream bundle valid.
- `in_ready` output 1: stage can accept.
- `in_data` input DATA_W: upstream data bundle.
- `in_ctrl` input CTRL_W: upstream control bundle.
- `flush` input 1: synchronous kill of all held and incoming entries.
- `out_valid` output 1: bundle at output is valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output DATA_W: registered data bundle.
- `out_ctrl` output CTRL_W: registered control bundle; equals CTRL_RST whenever `out_valid`=0.
- `occupancy` output 2: entries held, 0..2 (0..1 when SKID=0).

## Operation
- Storage:
  - main entry: `m_valid`, `m_data`, `m_ctrl`; drives the outputs directly.
  - skid entry: `s_valid`, `s_data`, `s_ctrl`; present only when SKID=1.
- Transfers:
  - accept = `in_valid` & `in_ready` & !`flush`.
  - drain = `m_valid` & `out_ready`.
- State, encoded as occupancy: EMPTY (0), ONE (main valid only), FULL (main and skid valid; SKID=1 only).
- SKID=1:
  - `in_ready` = !`s_valid`, taken directly from a flop.
  - EMPTY + accept → ONE; input loads main.
  - ONE + accept + drain → ONE; input loads main.
  - ONE + accept + !drain → FULL; input loads skid.
  - ONE + drain + !accept → EMPTY.
  - FULL + drain → ONE; skid moves to main. `in_ready` is 0 in FULL, so no accept occurs.
  - FULL + !drain → FULL; all contents held.
- SKID=0:
  - `in_ready` = !`m_valid` | `out_ready`.
  - accept loads main.
  - drain without accept → EMPTY.
- Flush:
  - Has priority over every transfer.
  - Next cycle: occupancy 0, `out_valid`=0, `out_ctrl`=CTRL_RST.
  - Data registers hold their previous value (don't-care).
  - An input offered in the flush cycle is discarded even if `in_ready`=1.
  - A drain in the flush cycle still counts as consumed by downstream.
- Control gating: `m_ctrl` and `s_ctrl` are loaded with CTRL_RST whenever their valid bit clears. A bubble therefore never presents RegWrite=1 or MemtoReg=1.
- Data stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_ctrl` hold bit-stable.
- Ordering: strictly FIFO. No entry is ever dropped except by flush or reset.

## Timing
- Reset, asynchronous on `rst` rising:
  - `out_valid`=0, `out_data`=0, `out_ctrl`=CTRL_RST, `occupancy`=0.
  - Skid entry cleared.
  - `in_ready`=1 for both SKID settings.
- Reset takes effect immediately, mid-transfer included. The first accept is possible on the first rising edge after `rst` deasserts.
- Latency: 1 cycle. A bundle accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Throughput: 1 bundle/cycle while `out_ready`=1, for both SKID settings.
- SKID=1 stall response:
  - `out_ready` falling at edge N: one more bundle may be accepted into skid at edge N. `in_ready`=0 after edge N.
  - `out_ready` rising again: `in_ready` returns to 1 one edge after the first drain.
- Simultaneous `flush` and `rst`: `rst` wins.

## Test plan
- Reset: hold `rst`=1 with random inputs → `out_valid`=0, `out_data`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1. Release, send D=0x1 → `out_data`=0x1 exactly one cycle later.
- Streaming: `out_ready`=1, 8 back-to-back bundles D=0..7 with ctrl=6'b100001 → outputs D=0..7 on consecutive cycles, `in_ready` constantly 1.
- Backpressure (SKID=1):
  - Streaming D=10,11,12 with `out_ready` dropped after accepting 10 → 10 held on output, 11 in skid, `occupancy`=2, `in_ready`=0.
  - Raise `out_ready` → 10, 11, 12 emerge in order, none lost or duplicated.
- Flush:
  - Setup: `occupancy`=2, ctrl RegWrite=1; assert `flush` for 1 cycle with `in_valid`=1 D=0x55.
  - Next cycle: `out_valid`=0, `out_ctrl`=0, `occupancy`=0.
  - 0x55 never appears at the output.
- Reset mid-operation: assert `rst` asynchronously while FULL with `out_ready`=0 → outputs clear before the next clock edge. After release, no stale bundle emerges.
- SKID=0 build: stall with `out_ready`=0 while full → `in_ready`=0 in the same cycle. Throughput and data order match the streaming scenario.
